// File: rtl/mouse_pkg.sv
// Shared types and display defaults for the cursor datapath (mouse_frame_ctl, draw_mouse).
package mouse_pkg;

    localparam int COORD_W      = 12;
    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_CUR_W    = 16;

    typedef enum logic [1:0] {
        WAIT_FIRST,
        ACTIVE,
        HIDDEN
    } mouse_state_t;

    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/mouse_click_slot.sv
// One-entry valid/ready holding register for click events; flags every event it has to discard.
module mouse_click_slot
    import mouse_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         rise_i,   // {right, left} rising edges
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic               btn_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               drop_o
);

    logic               valid_q, valid_d;
    logic               btn_q, btn_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               drop_q, drop_d;
    logic               free;

    // An entry being accepted this cycle frees the slot for a same-cycle reload.
    assign free = ~valid_q | ready_i;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        btn_d   = btn_q;
        x_d     = x_q;
        y_d     = y_q;
        drop_d  = 1'b0;
        if (|rise_i) begin
            if (free) begin
                valid_d = 1'b1;
                btn_d   = ~rise_i[0];   // left wins a simultaneous press
                x_d     = x_i;
                y_d     = y_i;
                drop_d  = &rise_i;
            end else begin
                drop_d  = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            btn_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            drop_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            btn_q   <= btn_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_o = valid_q;
    assign btn_o   = btn_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/mouse_frame_ctl.sv
// Cursor sequencer: clamps and frame-latches the mouse position, hides an idle cursor,
// and turns button rises into handshaked click events.
module mouse_frame_ctl
    import mouse_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int CUR_W       = DEF_CUR_W,
    parameter int IDLE_FRAMES = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] mouse_xpos,
    input  logic [COORD_W-1:0] mouse_ypos,
    input  logic               mouse_left,
    input  logic               mouse_right,
    input  logic               vblnk,
    output logic [COORD_W-1:0] cur_xpos,
    output logic [COORD_W-1:0] cur_ypos,
    output logic               cur_en,
    output logic               click_valid,
    input  logic               click_ready,
    output logic               click_btn,
    output logic [COORD_W-1:0] click_x,
    output logic [COORD_W-1:0] click_y,
    output logic               click_drop
);

    localparam int                 CNT_W    = $clog2(IDLE_FRAMES + 1);
    localparam logic [CNT_W-1:0]   IDLE_MAX = CNT_W'(IDLE_FRAMES);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_ACTIVE - CUR_W);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_ACTIVE - CUR_W);

    logic               vblnk_q;
    logic [1:0]         btn_q;
    logic [COORD_W-1:0] cx, cy;
    logic [COORD_W-1:0] cur_x_q, cur_y_q;
    logic               cur_en_q;
    logic [CNT_W-1:0]   idle_q, idle_d;
    mouse_state_t       state_q, state_d;
    logic               tick, moved, activity;
    logic [1:0]         btn_rise;

    assign cx       = clamp_coord(mouse_xpos, X_MAX);
    assign cy       = clamp_coord(mouse_ypos, Y_MAX);
    assign tick     = vblnk & ~vblnk_q;
    assign moved    = tick && ((cx != cur_x_q) || (cy != cur_y_q));
    assign btn_rise = {mouse_right, mouse_left} & ~btn_q;
    assign activity = moved | (|btn_rise);

    always_comb begin
        idle_d = idle_q;
        if (activity) begin
            idle_d = '0;
        end else if (tick && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Hide on the tick that makes the count reach the limit, so cur_en drops one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FIRST, HIDDEN: if (activity) state_d = ACTIVE;
            ACTIVE:             if (idle_d == IDLE_MAX) state_d = HIDDEN;
            default:            state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q  <= 1'b0;
            btn_q    <= 2'b00;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            cur_en_q <= 1'b0;
            idle_q   <= '0;
            state_q  <= WAIT_FIRST;
        end else begin
            vblnk_q  <= vblnk;
            btn_q    <= {mouse_right, mouse_left};
            idle_q   <= idle_d;
            state_q  <= state_d;
            cur_en_q <= (state_q == ACTIVE);
            if (tick) begin
                cur_x_q <= cx;
                cur_y_q <= cy;
            end
        end
    end

    assign cur_xpos = cur_x_q;
    assign cur_ypos = cur_y_q;
    assign cur_en   = cur_en_q;

    mouse_click_slot u_click_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .rise_i  (btn_rise),
        .x_i     (cx),
        .y_i     (cy),
        .ready_i (click_ready),
        .valid_o (click_valid),
        .btn_o   (click_btn),
        .x_o     (click_x),
        .y_o     (click_y),
        .drop_o  (click_drop)
    );

endmodule
